// File: rtl/ball_renderer.sv
// -----------------------------------------------------------------------------
// ball_renderer
//
// Turns each new ball position into a stream of single-pixel writes for a VGA
// adapter. The previous ball square is erased in the background colour, then
// the new square is drawn in the ball colour. A full-screen clear sweeps every
// visible pixel in the background colour on request.
//
// Ports
//   clock       in   1  system clock, all state on rising edge
//   reset       in   1  asynchronous, active-low reset
//   pos_valid   in   1  new-position strobe, accepted only while ready=1
//   xpos        in   8  ball top-left x, sampled on acceptance
//   ypos        in   8  ball top-left y, sampled on acceptance
//   clear_req   in   1  full-screen clear request, accepted only while ready=1
//   ready       out  1  1 = idle, can accept pos_valid or clear_req
//   vga_x       out  8  pixel x
//   vga_y       out  7  pixel y
//   vga_colour  out  3  pixel colour
//   vga_plot    out  1  1 = write vga_x/vga_y/vga_colour this cycle
//   frame_done  out  1  one-cycle pulse when an update or clear completes
//
// Timing model: every output is registered from the *next* state, so the
// registered state always names the operation whose pixel is currently on the
// outputs. An operation accepted on one edge shows its first pixel right after
// that edge; the counters hold the offset of the pixel being shown.
// -----------------------------------------------------------------------------
module ball_renderer #(
  parameter int unsigned BALL_SIZE   = 2,
  parameter logic [2:0]  BALL_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pos_valid,
  input  logic [7:0] xpos,
  input  logic [7:0] ypos,
  input  logic       clear_req,
  output logic       ready,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_CLEAR,
    S_DONE
  } state_t;

  // Counters and coordinate sums share one 9-bit width so that ball offsets
  // added to a top-left near the screen edge never wrap back on screen.
  localparam logic [8:0] LAST_OFS = 9'(BALL_SIZE - 1);
  localparam logic [8:0] LAST_X   = 9'(SCREEN_W - 1);
  localparam logic [8:0] LAST_Y   = 9'(SCREEN_H - 1);
  localparam logic [8:0] SCR_W    = 9'(SCREEN_W);
  localparam logic [8:0] SCR_H    = 9'(SCREEN_H);

  // Registered state
  state_t     r_state;
  logic [8:0] r_cx;
  logic [8:0] r_cy;
  logic [7:0] r_new_x;
  logic [7:0] r_new_y;
  logic [7:0] r_old_x;
  logic [7:0] r_old_y;
  logic       r_have_old;
  logic       r_from_clear;

  // Registered outputs
  logic       r_ready;
  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_vga_colour;
  logic       r_vga_plot;
  logic       r_frame_done;

  // Next-state / next-pixel decode
  state_t     w_state_n;
  logic [8:0] w_cx_n;
  logic [8:0] w_cy_n;
  logic [7:0] w_base_x;
  logic [7:0] w_base_y;
  logic [2:0] w_colour;
  logic       w_emit;
  logic       w_latch_new;
  logic       w_start_clear;
  logic       w_last_ball;
  logic       w_last_clear;
  logic [8:0] w_px;
  logic [8:0] w_py;
  logic       w_on_screen;

  assign w_last_ball  = (r_cx == LAST_OFS) && (r_cy == LAST_OFS);
  assign w_last_clear = (r_cx == LAST_X)   && (r_cy == LAST_Y);

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that forgets one would otherwise infer a latch.
  always_comb begin
    w_state_n     = r_state;
    w_cx_n        = r_cx;
    w_cy_n        = r_cy;
    w_base_x      = r_new_x;
    w_base_y      = r_new_y;
    w_colour      = BALL_COLOUR;
    w_emit        = 1'b0;
    w_latch_new   = 1'b0;
    w_start_clear = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          // Clear wins over a same-cycle position, which is simply dropped.
          w_state_n     = S_CLEAR;
          w_cx_n        = '0;
          w_cy_n        = '0;
          w_base_x      = '0;
          w_base_y      = '0;
          w_colour      = BG_COLOUR;
          w_emit        = 1'b1;
          w_start_clear = 1'b1;
        end else if (pos_valid) begin
          w_latch_new = 1'b1;
          w_cx_n      = '0;
          w_cy_n      = '0;
          w_emit      = 1'b1;
          if (r_have_old) begin
            w_state_n = S_ERASE;
            w_base_x  = r_old_x;
            w_base_y  = r_old_y;
            w_colour  = BG_COLOUR;
          end else begin
            // First pixel comes straight from the inputs; the new-position
            // registers are only written on this same edge.
            w_state_n = S_DRAW;
            w_base_x  = xpos;
            w_base_y  = ypos;
          end
        end
      end

      S_ERASE: begin
        w_emit = 1'b1;
        if (w_last_ball) begin
          w_state_n = S_DRAW;
          w_cx_n    = '0;
          w_cy_n    = '0;
        end else begin
          w_base_x = r_old_x;
          w_base_y = r_old_y;
          w_colour = BG_COLOUR;
          if (r_cx == LAST_OFS) begin
            w_cx_n = '0;
            w_cy_n = r_cy + 9'd1;
          end else begin
            w_cx_n = r_cx + 9'd1;
          end
        end
      end

      S_DRAW: begin
        if (w_last_ball) begin
          w_state_n = S_DONE;
        end else begin
          w_emit = 1'b1;
          if (r_cx == LAST_OFS) begin
            w_cx_n = '0;
            w_cy_n = r_cy + 9'd1;
          end else begin
            w_cx_n = r_cx + 9'd1;
          end
        end
      end

      S_CLEAR: begin
        if (w_last_clear) begin
          w_state_n = S_DONE;
        end else begin
          w_base_x = '0;
          w_base_y = '0;
          w_colour = BG_COLOUR;
          w_emit   = 1'b1;
          if (r_cx == LAST_X) begin
            w_cx_n = '0;
            w_cy_n = r_cy + 9'd1;
          end else begin
            w_cx_n = r_cx + 9'd1;
          end
        end
      end

      S_DONE: begin
        w_state_n = S_IDLE;
      end

      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Off-screen pixels still consume their cycle but are not plotted, so the
  // update length does not depend on the ball position.
  assign w_px        = {1'b0, w_base_x} + w_cx_n;
  assign w_py        = {1'b0, w_base_y} + w_cy_n;
  assign w_on_screen = w_emit && (w_px < SCR_W) && (w_py < SCR_H);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cx         <= '0;
      r_cy         <= '0;
      r_new_x      <= '0;
      r_new_y      <= '0;
      r_old_x      <= '0;
      r_old_y      <= '0;
      r_have_old   <= 1'b0;
      r_from_clear <= 1'b0;
      r_ready      <= 1'b1;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cx         <= w_cx_n;
      r_cy         <= w_cy_n;
      r_ready      <= (w_state_n == S_IDLE);
      r_frame_done <= (w_state_n == S_DONE);
      r_vga_plot   <= w_on_screen;

      // Pixel bus holds its last value whenever nothing is plotted.
      if (w_on_screen) begin
        r_vga_x      <= w_px[7:0];
        r_vga_y      <= w_py[6:0];
        r_vga_colour <= w_colour;
      end

      if (w_latch_new) begin
        r_new_x <= xpos;
        r_new_y <= ypos;
      end

      if (w_start_clear) begin
        r_from_clear <= 1'b1;
        r_have_old   <= 1'b0;
      end

      // Leaving DONE: a finished update becomes the square to erase next time;
      // a finished clear leaves nothing on screen to erase.
      if (r_state == S_DONE) begin
        r_from_clear <= 1'b0;
        if (!r_from_clear) begin
          r_old_x    <= r_new_x;
          r_old_y    <= r_new_y;
          r_have_old <= 1'b1;
        end
      end
    end
  end

  assign ready      = r_ready;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ball_renderer.sv
// -----------------------------------------------------------------------------
// tb_ball_renderer
//
// Directed bench for ball_renderer with default parameters (2x2 ball, 160x120).
// Expected pixel streams are built from hand-chosen squares; the pixel bus is
// also checked to hold its last plotted value on non-plot cycles.
// -----------------------------------------------------------------------------
module tb_ball_renderer;

  logic       clock;
  logic       reset;
  logic       pos_valid;
  logic [7:0] xpos;
  logic [7:0] ypos;
  logic       clear_req;
  logic       ready;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       frame_done;

  ball_renderer dut (
    .clock      (clock),
    .reset      (reset),
    .pos_valid  (pos_valid),
    .xpos       (xpos),
    .ypos       (ypos),
    .clear_req  (clear_req),
    .ready      (ready),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .frame_done (frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  string      cname;
  // Last value expected on the pixel bus (it holds between plots).
  logic [7:0] hx;
  logic [6:0] hy;
  logic [2:0] hc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Append the expected per-cycle stream for one 2x2 square at (bx,by).
  task automatic push_square(input int bx, input int by, input logic [2:0] c);
    pix_t p;
    for (int cy = 0; cy < 2; cy++) begin
      for (int cx = 0; cx < 2; cx++) begin
        p.plot = ((bx + cx) < 160) && ((by + cy) < 120);
        p.x    = 8'(bx + cx);
        p.y    = 7'(by + cy);
        p.c    = c;
        exp_q.push_back(p);
      end
    end
  endtask

  // Issue one position and compare every cycle against exp_q; frame_done is
  // expected on the cycle after the last queued pixel. If inject_at > 0, a
  // stray pos_valid (50,50) is pulsed after that cycle's sample.
  task automatic do_update(input logic [7:0] x, input logic [7:0] y, input int inject_at);
    int   d;
    pix_t p;
    d = exp_q.size() + 1;
    check($sformatf("%s ready_before", cname), 32'(ready), 32'd1);
    @(negedge clock);
    pos_valid = 1'b1;
    xpos      = x;
    ypos      = y;
    @(posedge clock);
    #1;
    pos_valid = 1'b0;
    for (int k = 1; k <= d; k++) begin
      if (k < d) begin
        p = exp_q[k-1];
        if (p.plot) begin
          hx = p.x;
          hy = p.y;
          hc = p.c;
        end
        check($sformatf("%s k%0d plot", cname, k), 32'(vga_plot), 32'(p.plot));
        check($sformatf("%s k%0d x", cname, k), 32'(vga_x), 32'(hx));
        check($sformatf("%s k%0d y", cname, k), 32'(vga_y), 32'(hy));
        check($sformatf("%s k%0d colour", cname, k), 32'(vga_colour), 32'(hc));
        check($sformatf("%s k%0d frame_done", cname, k), 32'(frame_done), 32'd0);
      end else begin
        check($sformatf("%s k%0d frame_done", cname, k), 32'(frame_done), 32'd1);
        check($sformatf("%s k%0d plot", cname, k), 32'(vga_plot), 32'd0);
      end
      check($sformatf("%s k%0d ready", cname, k), 32'(ready), 32'd0);
      if (k == inject_at) begin
        pos_valid = 1'b1;
        xpos      = 8'd50;
        ypos      = 8'd50;
      end
      @(posedge clock);
      #1;
      pos_valid = 1'b0;
    end
    check($sformatf("%s ready_after", cname), 32'(ready), 32'd1);
    check($sformatf("%s frame_done_after", cname), 32'(frame_done), 32'd0);
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    hx = '0;
    hy = '0;
    hc = '0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n_plots;
    int n_bad;
    int ex;
    int ey;

    reset     = 1'b0;
    pos_valid = 1'b0;
    clear_req = 1'b0;
    xpos      = '0;
    ypos      = '0;
    hx        = '0;
    hy        = '0;
    hc        = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset ready", 32'(ready), 32'd1);
    check("reset plot", 32'(vga_plot), 32'd0);
    check("reset x", 32'(vga_x), 32'd0);
    check("reset y", 32'(vga_y), 32'd0);
    check("reset colour", 32'(vga_colour), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // 1: first position, no erase; (10,20)(11,20)(10,21)(11,21) then done at +5
    cname = "c1";
    push_square(10, 20, 3'd7);
    do_update(8'd10, 8'd20, 0);

    // 2: move to (12,20): erase old square in colour 0, then draw; done at +9
    cname = "c2";
    push_square(10, 20, 3'd0);
    push_square(12, 20, 3'd7);
    do_update(8'd12, 8'd20, 0);

    // 3: after reset, corner (159,119): only one on-screen pixel, done at +5
    pulse_reset();
    cname = "c3";
    push_square(159, 119, 3'd7);
    do_update(8'd159, 8'd119, 0);

    // 4: stray pos_valid during DRAW is ignored; erase of (159,119) plots once
    cname = "c4a";
    push_square(159, 119, 3'd0);
    push_square(20, 30, 3'd7);
    do_update(8'd20, 8'd30, 6);
    // old position must still be (20,30), not (50,50)
    cname = "c4b";
    push_square(20, 30, 3'd0);
    push_square(40, 40, 3'd7);
    do_update(8'd40, 8'd40, 0);

    // 4c: same position again still erases then draws
    cname = "c4c";
    push_square(40, 40, 3'd0);
    push_square(40, 40, 3'd7);
    do_update(8'd40, 8'd40, 0);

    // 5: clear_req with a same-cycle pos_valid: full sweep, position dropped
    cname = "c5";
    check("c5 ready_before", 32'(ready), 32'd1);
    @(negedge clock);
    clear_req = 1'b1;
    pos_valid = 1'b1;
    xpos      = 8'd70;
    ypos      = 8'd70;
    @(posedge clock);
    #1;
    clear_req = 1'b0;
    pos_valid = 1'b0;
    n_plots   = 0;
    n_bad     = 0;
    ex        = 0;
    ey        = 0;
    for (int k = 1; k <= 19201; k++) begin
      if (k < 19201) begin
        if (!vga_plot || frame_done || ready) begin
          n_bad++;
        end else begin
          n_plots++;
          if (int'(vga_x) != ex || int'(vga_y) != ey || vga_colour != 3'd0) n_bad++;
          if (ex == 159) begin
            ex = 0;
            ey++;
          end else begin
            ex++;
          end
        end
      end else begin
        check("c5 frame_done", 32'(frame_done), 32'd1);
        check("c5 plot_at_done", 32'(vga_plot), 32'd0);
      end
      @(posedge clock);
      #1;
    end
    check("c5 sweep_errors", 32'(n_bad), 32'd0);
    check("c5 plot_count", 32'(n_plots), 32'd19200);
    check("c5 last_x", 32'(vga_x), 32'd159);
    check("c5 last_y", 32'(vga_y), 32'd119);
    check("c5 ready_after", 32'(ready), 32'd1);
    hx = 8'd159;
    hy = 7'd119;
    hc = 3'd0;
    // next position draws without an erase
    cname = "c5b";
    push_square(5, 6, 3'd7);
    do_update(8'd5, 8'd6, 0);

    // 6: reset mid-DRAW drops the update
    cname = "c6";
    check("c6 ready_before", 32'(ready), 32'd1);
    @(negedge clock);
    pos_valid = 1'b1;
    xpos      = 8'd1;
    ypos      = 8'd1;
    @(posedge clock);
    #1;
    pos_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    // cycle 6: second DRAW pixel (2,1)
    check("c6 mid_plot", 32'(vga_plot), 32'd1);
    check("c6 mid_x", 32'(vga_x), 32'd2);
    check("c6 mid_y", 32'(vga_y), 32'd1);
    check("c6 mid_colour", 32'(vga_colour), 32'd7);
    reset = 1'b0;
    #1;
    check("c6 rst_plot", 32'(vga_plot), 32'd0);
    check("c6 rst_ready", 32'(ready), 32'd1);
    check("c6 rst_x", 32'(vga_x), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    hx = '0;
    hy = '0;
    hc = '0;
    @(posedge clock);
    #1;
    check("c6 ready_after_release", 32'(ready), 32'd1);
    check("c6 plot_after_release", 32'(vga_plot), 32'd0);
    cname = "c6b";
    push_square(3, 3, 3'd7);
    do_update(8'd3, 8'd3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
